// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM endpoint: word-organised memory with byte-lane writes,
// programmable wait states and two-cycle ERROR responses for illegal accesses.
module ahb_lite_sram_slave #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int AHB_DATA_WIDTH = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      hsel,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic [2:0]                hburst,
  input  logic [3:0]                hprot,
  input  logic                      hmastlock,
  input  logic                      hready,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata,
  output logic [AHB_DATA_WIDTH-1:0] hrdata,
  output logic                      hreadyout,
  output logic                      hresp
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] WS = CW'(WAIT_STATES);

  if (AHB_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("ahb_lite_sram_slave: AHB_DATA_WIDTH must be 32");
  end
  if (MEM_DEPTH < 4 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ahb_lite_sram_slave: MEM_DEPTH must be a power of two >= 4");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("ahb_lite_sram_slave: WAIT_STATES must be 0..15");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IW-1:0]   idx_q;
  logic [1:0]      lane_q;
  logic [1:0]      size_q;
  logic            write_q;
  logic            accept, illegal, latch;
  logic            size_bad, misalign, oob;
  logic [AHB_ADDR_WIDTH-1:0] word_idx;
  logic [3:0]      be;
  logic [AHB_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic unused_inputs;
  assign unused_inputs = ^{hburst, hprot, hmastlock};

  assign accept   = hsel & hready & htrans[1];
  assign word_idx = haddr >> 2;
  assign size_bad = hsize > 3'd2;
  assign misalign = (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'b00);
  assign oob      = word_idx >= AHB_ADDR_WIDTH'(MEM_DEPTH);
  assign illegal  = size_bad | misalign | oob;
  assign cnt_inc  = cnt_q + CW'(1);

  // Accepts are only looked at in states that drive hreadyout high.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch     = 1'b0;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_inc == WS) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      default: begin
        hresp = (state_q == S_ERR2);
        cnt_d = '0;
        latch = accept;
        if (!accept)           state_d = S_IDLE;
        else if (illegal)      state_d = S_ERR1;
        else if (WS != '0)     state_d = S_WAIT;
        else                   state_d = S_DATA;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        idx_q   <= haddr[IW+1:2];
        lane_q  <= haddr[1:0];
        size_q  <= hsize[1:0];
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    be = 4'b0001 << lane_q;
      2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Commit happens on the edge that ends DATA; reset forces IDLE so it is skipped.
  always_ff @(posedge hclk) begin
    if (state_q == S_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (state_q == S_DATA && !write_q) ? mem_q[idx_q] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: a zero-wait instance (u_dut0) and a three-wait instance (u_dut3)
// share the bus inputs; each has its own select and its own hready loopback.
module tb_ahb_lite_sram_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata0, hrdata3;
  logic        hreadyout0, hreadyout3, hresp0, hresp3;
  logic        hready0, hready3;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  assign hready0 = hreadyout0;
  assign hready3 = hreadyout3;

  ahb_lite_sram_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0),
    .hready(hready0), .hwdata(hwdata), .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0)
  );

  ahb_lite_sram_slave #(.AHB_ADDR_WIDTH(32), .AHB_DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0),
    .hready(hready3), .hwdata(hwdata), .hrdata(hrdata3), .hreadyout(hreadyout3), .hresp(hresp3)
  );

  // Tasks begin and end at the drive point, 1 ns after a rising edge.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_addr(input logic s0, input logic s3, input logic wr,
                            input logic [31:0] a, input logic [2:0] sz);
    hsel0  = s0;
    hsel3  = s3;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
    htrans = 2'b10;
  endtask

  task automatic drive_idle();
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  task automatic xfer0(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd);
    drive_addr(1'b1, 1'b0, wr, a, sz);
    cyc();
    hwdata = wd;
    drive_idle();
    @(negedge hclk);
    rd = hrdata0;
    cyc();
  endtask

  // Counts hreadyout-low cycles on u_dut3; leaves time at the negedge of the ready cycle.
  task automatic wait3(output int lows, output bit done);
    lows = 0;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge hclk);
      if (hreadyout3 === 1'b1) begin
        done = 1'b1;
        break;
      end
      lows++;
      checks++;
      if (hrdata3 !== 32'h0) begin
        errors++;
        $display("FAIL wait_hrdata got %h exp 00000000", hrdata3);
      end
      @(posedge hclk);
      #1;
    end
  endtask

  task automatic xfer3(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rd, output int lows);
    bit done;
    drive_addr(1'b0, 1'b1, wr, a, sz);
    cyc();
    hwdata = wd;
    drive_idle();
    wait3(lows, done);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL wait_timeout got hreadyout=%b exp 1 within 20 cycles", hreadyout3);
    end
    rd = hrdata3;
    cyc();
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    drive_idle();
    haddr  = '0;
    hsize  = 3'd0;
    hwdata = '0;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL rst_hold_hreadyout got %b exp 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL rst_hold_hresp got %b exp 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL rst_hold_hrdata got %h exp 0", hrdata0); end
    cyc();
    hresetn = 1'b1;
    @(negedge hclk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL rst_rel_hreadyout got %b exp 1", hreadyout0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL rst_rel_hresp got %b exp 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL rst_rel_hrdata got %h exp 0", hrdata0); end
    checks++; if ({hreadyout3, hresp3} !== 2'b10) begin errors++; $display("FAIL rst_rel_dut3 got %b exp 10", {hreadyout3, hresp3}); end
    checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL rst_rel_dut3_hrdata got %h exp 0", hrdata3); end
    cyc();
  endtask

  task automatic test_zero_wait();
    drive_addr(1'b1, 1'b0, 1'b1, 32'h10, 3'd2);
    @(negedge hclk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL zw_addr_hreadyout got %b exp 1", hreadyout0); end
    cyc();
    hwdata = 32'hDEADBEEF;
    drive_addr(1'b1, 1'b0, 1'b0, 32'h10, 3'd2);
    @(negedge hclk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL zw_wdata_hreadyout got %b exp 1", hreadyout0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL zw_wdata_hrdata got %h exp 0", hrdata0); end
    cyc();
    drive_idle();
    hwdata = 32'h0;
    @(negedge hclk);
    checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL zw_rdata_hreadyout got %b exp 1", hreadyout0); end
    checks++; if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rdata got %h exp DEADBEEF", hrdata0); end
    cyc();
    @(negedge hclk);
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL zw_idle_hrdata got %h exp 0", hrdata0); end
    cyc();
  endtask

  task automatic test_idle_busy();
    logic [31:0] rd;
    hsel0  = 1'b1;
    htrans = 2'b01;
    hwrite = 1'b1;
    haddr  = 32'h10;
    hsize  = 3'd2;
    cyc();
    hwdata = 32'h0BAD0BAD;
    htrans = 2'b00;
    @(negedge hclk);
    checks++; if ({hreadyout0, hresp0} !== 2'b10) begin errors++; $display("FAIL busy_okay got %b exp 10", {hreadyout0, hresp0}); end
    cyc();
    drive_idle();
    xfer0(1'b0, 32'h10, 3'd2, 32'h0, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL busy_no_write got %h exp DEADBEEF", rd); end
  endtask

  task automatic test_lanes();
    drive_addr(1'b1, 1'b0, 1'b1, 32'h20, 3'd2);
    cyc();
    hwdata = 32'h00000000;
    drive_addr(1'b1, 1'b0, 1'b1, 32'h21, 3'd0);
    cyc();
    hwdata = 32'h1122AA33;
    drive_addr(1'b1, 1'b0, 1'b1, 32'h22, 3'd1);
    cyc();
    hwdata = 32'hBBCC5566;
    drive_addr(1'b1, 1'b0, 1'b0, 32'h20, 3'd2);
    cyc();
    drive_idle();
    @(negedge hclk);
    checks++; if (hrdata0 !== 32'hBBCCAA00) begin errors++; $display("FAIL lanes_rdata got %h exp BBCCAA00", hrdata0); end
    checks++; if ({hreadyout0, hresp0} !== 2'b10) begin errors++; $display("FAIL lanes_okay got %b exp 10", {hreadyout0, hresp0}); end
    cyc();
  endtask

  task automatic test_error();
    logic [31:0] rd;
    xfer0(1'b1, 32'h0, 3'd2, 32'hCAFEF00D, rd);
    drive_addr(1'b1, 1'b0, 1'b0, 32'h1002, 3'd2);
    cyc();
    drive_idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    checks++; if ({hreadyout0, hresp0} !== 2'b01) begin errors++; $display("FAIL err1_rd got %b exp 01", {hreadyout0, hresp0}); end
    cyc();
    drive_addr(1'b1, 1'b0, 1'b1, 32'h1000, 3'd0);
    @(negedge hclk);
    checks++; if ({hreadyout0, hresp0} !== 2'b11) begin errors++; $display("FAIL err2_rd got %b exp 11", {hreadyout0, hresp0}); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL err2_rd_hrdata got %h exp 0", hrdata0); end
    cyc();
    drive_idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge hclk);
    checks++; if ({hreadyout0, hresp0} !== 2'b01) begin errors++; $display("FAIL err1_wr got %b exp 01", {hreadyout0, hresp0}); end
    cyc();
    @(negedge hclk);
    checks++; if ({hreadyout0, hresp0} !== 2'b11) begin errors++; $display("FAIL err2_wr got %b exp 11", {hreadyout0, hresp0}); end
    cyc();
    @(negedge hclk);
    checks++; if ({hreadyout0, hresp0} !== 2'b10) begin errors++; $display("FAIL err_after_idle got %b exp 10", {hreadyout0, hresp0}); end
    cyc();
    xfer0(1'b0, 32'h0, 3'd2, 32'h0, rd);
    checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL err_mem0 got %h exp CAFEF00D", rd); end
    xfer0(1'b0, 32'h10, 3'd2, 32'h0, rd);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem10 got %h exp DEADBEEF", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd;
    int lows;
    xfer3(1'b1, 32'h8, 3'd2, 32'h12345678, rd, lows);
    checks++; if (lows !== 3) begin errors++; $display("FAIL ws_write_lows got %0d exp 3", lows); end
    xfer3(1'b0, 32'h8, 3'd2, 32'h0, rd, lows);
    checks++; if (lows !== 3) begin errors++; $display("FAIL ws_read_lows got %0d exp 3", lows); end
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ws_read_data got %h exp 12345678", rd); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd;
    int lows;
    xfer3(1'b1, 32'h40, 3'd2, 32'h55AA55AA, rd, lows);
    drive_addr(1'b0, 1'b1, 1'b1, 32'h40, 3'd2);
    cyc();
    hwdata = 32'hFFFFFFFF;
    drive_idle();
    @(negedge hclk);
    checks++; if (hreadyout3 !== 1'b0) begin errors++; $display("FAIL rmw_in_wait got %b exp 0", hreadyout3); end
    #2;
    hresetn = 1'b0;
    #1;
    checks++; if ({hreadyout3, hresp3} !== 2'b10) begin errors++; $display("FAIL rmw_async_out got %b exp 10", {hreadyout3, hresp3}); end
    checks++; if (hrdata3 !== 32'h0) begin errors++; $display("FAIL rmw_async_hrdata got %h exp 0", hrdata3); end
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    cyc();
    xfer3(1'b0, 32'h40, 3'd2, 32'h0, rd, lows);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL rmw_mem got %h exp 55AA55AA", rd); end
    checks++; if (lows !== 3) begin errors++; $display("FAIL rmw_read_lows got %0d exp 3", lows); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_idle_busy();
    test_lanes();
    test_error();
    test_wait_states();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
